// File: rtl/binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq
//   Sequential 8-bit binary to 3-digit BCD converter (double-dabble), one
//   iteration per clock. Optionally treats the operand as two's complement and
//   reports the sign separately from the BCD magnitude.
//
// Ports
//   CLOCK_50     in   single clock, all state changes on the rising edge
//   RESET        in   synchronous, active-high reset
//   start        in   conversion request, only looked at while idle
//   signed_mode  in   1: bin_in is two's complement, 0: unsigned
//   bin_in       in   8-bit operand, captured on the accept edge
//   busy         out  high while a conversion is in progress (not idle)
//   done         out  one-cycle pulse, result outputs valid
//   bcd_100      out  hundreds digit of the magnitude (0..2)
//   bcd_10       out  tens digit of the magnitude
//   bcd_1        out  units digit of the magnitude
//   negative     out  sign of the last converted operand
//
// Parameter
//   CLEAR_ON_START  when 1, result outputs are zeroed on the accept edge and
//                   stay zero until the new result lands.
// ---------------------------------------------------------------------------
module binary_to_bcd_seq #(
  parameter bit CLEAR_ON_START = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  input  logic       signed_mode,
  input  logic [7:0] bin_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_100,
  output logic [3:0] bcd_10,
  output logic [3:0] bcd_1,
  output logic       negative
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Double-dabble correction: a digit of 5 or more would overflow past 9
  // after the next doubling, so pre-add 3 to carry into the next digit.
  function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
    logic [3:0] res;
    if (digit >= 4'd5) begin
      res = digit + 4'd3;
    end else begin
      res = digit;
    end
    return res;
  endfunction

  // One full iteration on the {hundreds, tens, units, binary} register:
  // correct every BCD digit, then shift the whole register left by one.
  function automatic logic [19:0] dd_step(input logic [19:0] reg_in);
    logic [19:0] adj;
    adj = {dd_adjust(reg_in[19:16]), dd_adjust(reg_in[15:12]),
           dd_adjust(reg_in[11:8]), reg_in[7:0]};
    return {adj[18:0], 1'b0};
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  cnt_r;
  logic [19:0] shift_r;
  logic [19:0] step_s;
  logic        sign_r;
  logic        neg_s;
  logic [7:0]  mag_s;
  logic        busy_r;
  logic        busy_s;
  logic        done_r;
  logic        done_s;
  logic [3:0]  bcd_100_r;
  logic [3:0]  bcd_10_r;
  logic [3:0]  bcd_1_r;
  logic        negative_r;

  // Operand sign/magnitude; 8'h80 negates to itself, which read unsigned is 128.
  always_comb begin
    neg_s = signed_mode & bin_in[7];
    if (neg_s) begin
      mag_s = (~bin_in) + 8'd1;
    end else begin
      mag_s = bin_in;
    end
  end

  // Next value of the conversion register after one iteration.
  always_comb begin
    step_s = dd_step(shift_r);
  end

  // Next-state logic; busy/done are derived from the next state so they can
  // be registered alongside the state itself.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == 3'd7) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State register and registered status flags.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Datapath: operand capture, iterations, and result publication on the
  // final iteration so all four result outputs change together.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_r      <= 3'd0;
      shift_r    <= 20'd0;
      sign_r     <= 1'b0;
      bcd_100_r  <= 4'd0;
      bcd_10_r   <= 4'd0;
      bcd_1_r    <= 4'd0;
      negative_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r   <= 3'd0;
            shift_r <= {12'd0, mag_s};
            sign_r  <= neg_s;
            if (CLEAR_ON_START) begin
              bcd_100_r  <= 4'd0;
              bcd_10_r   <= 4'd0;
              bcd_1_r    <= 4'd0;
              negative_r <= 1'b0;
            end
          end
        end
        SHIFT: begin
          shift_r <= step_s;
          cnt_r   <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            bcd_100_r  <= step_s[19:16];
            bcd_10_r   <= step_s[15:12];
            bcd_1_r    <= step_s[11:8];
            negative_r <= sign_r;
          end
        end
        DONE: begin
          cnt_r <= 3'd0;
        end
        default: begin
          cnt_r <= 3'd0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd_100  = bcd_100_r;
  assign bcd_10   = bcd_10_r;
  assign bcd_1    = bcd_1_r;
  assign negative = negative_r;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq: a cycle-level reference model
// (edge counting and decimal arithmetic) is compared against the DUT on every
// falling edge, and directed conversions pin both model and DUT to literals.
module tb_binary_to_bcd_seq;

  logic       clk;
  logic       RESET;
  logic       start;
  logic       signed_mode;
  logic [7:0] bin_in;
  logic       busy;
  logic       done;
  logic [3:0] bcd_100;
  logic [3:0] bcd_10;
  logic [3:0] bcd_1;
  logic       negative;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  bit cmp_en = 1'b0;

  binary_to_bcd_seq dut (
    .CLOCK_50   (clk),
    .RESET      (RESET),
    .start      (start),
    .signed_mode(signed_mode),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_100    (bcd_100),
    .bcd_10     (bcd_10),
    .bcd_1      (bcd_1),
    .negative   (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_phase: -1 idle, otherwise number of edges since the accept edge.
  int         m_phase = -1;
  int         cap_mag = 0;
  logic       cap_neg = 1'b0;
  logic       m_busy, m_done, m_neg;
  logic [3:0] m_h, m_t, m_u;

  function automatic int ref_mag(input logic [7:0] v, input logic sm);
    if (sm && v > 8'd127) return 256 - int'(v);
    return int'(v);
  endfunction

  always @(posedge clk) begin
    if (RESET) begin
      m_phase <= -1; m_busy <= 1'b0; m_done <= 1'b0;
      m_h <= 4'd0; m_t <= 4'd0; m_u <= 4'd0; m_neg <= 1'b0;
    end else if (m_phase < 0) begin
      m_done <= 1'b0;
      if (start) begin
        m_phase <= 0;
        m_busy  <= 1'b1;
        cap_mag <= ref_mag(bin_in, signed_mode);
        cap_neg <= signed_mode & bin_in[7];
      end
    end else if (m_phase == 7) begin
      m_phase <= 8;
      m_done  <= 1'b1;
      m_h     <= 4'(cap_mag / 100);
      m_t     <= 4'((cap_mag / 10) % 10);
      m_u     <= 4'(cap_mag % 10);
      m_neg   <= cap_neg;
    end else if (m_phase == 8) begin
      m_phase <= -1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if ({busy, done, bcd_100, bcd_10, bcd_1, negative} !==
          {m_busy, m_done, m_h, m_t, m_u, m_neg}) begin
        errors++;
        $display("FAIL model_cmp t=%0t dut b=%b d=%b %0d/%0d/%0d n=%b expected b=%b d=%b %0d/%0d/%0d n=%b",
                 $time, busy, done, bcd_100, bcd_10, bcd_1, negative,
                 m_busy, m_done, m_h, m_t, m_u, m_neg);
      end
      checks++;
      if (bcd_100 > 4'd2 || bcd_10 > 4'd9 || bcd_1 > 4'd9) begin
        errors++;
        $display("FAIL digit_range t=%0t got %0d/%0d/%0d required hundreds<=2 others<=9",
                 $time, bcd_100, bcd_10, bcd_1);
      end
      if (done) done_total++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  // Directed conversion: garbage on the inputs after acceptance must not matter.
  task automatic run_conv(input string name, input logic [7:0] val, input logic sm,
                          input int eh, input int et, input int eu, input int en);
    int busy_cnt, done_cnt, done_at;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; bin_in = val; signed_mode = sm;
    @(posedge clk); #1;                 // E0
    start = 1'b0; bin_in = 8'($urandom); signed_mode = 1'($urandom);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);                   // between E(i) and E(i+1)
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = i; end
    end
    chk({name, "_busy_cycles"}, busy_cnt, 9);
    chk({name, "_done_count"}, done_cnt, 1);
    chk({name, "_done_edge"}, done_at, 8);
    chk({name, "_hundreds"}, int'(bcd_100), eh);
    chk({name, "_tens"}, int'(bcd_10), et);
    chk({name, "_units"}, int'(bcd_1), eu);
    chk({name, "_negative"}, int'(negative), en);
    chk({name, "_model_digits"}, int'(m_h) * 100 + int'(m_t) * 10 + int'(m_u),
        eh * 100 + et * 10 + eu);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1;
    RESET = 1'b1; start = 1'b0; signed_mode = 1'b0; bin_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    RESET = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_digits", int'({bcd_100, bcd_10, bcd_1}), 0);
    chk("reset_negative", int'(negative), 0);

    run_conv("u_ff",   8'hFF, 1'b0, 2, 5, 5, 0);
    run_conv("s_80",   8'h80, 1'b1, 1, 2, 8, 1);
    run_conv("s_7f",   8'h7F, 1'b1, 1, 2, 7, 0);
    run_conv("s_f6",   8'hF6, 1'b1, 0, 1, 0, 1);
    run_conv("u_f6",   8'hF6, 1'b0, 2, 4, 6, 0);
    run_conv("s_zero", 8'h00, 1'b1, 0, 0, 0, 0);

    // Start with 37, a second start with 99 at E3 must be ignored.
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; bin_in = 8'd37; signed_mode = 1'b0;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; bin_in = 8'd99;
    @(posedge clk); #1;                 // E3
    start = 1'b0;
    d0 = done_total;
    repeat (10) @(negedge clk);
    chk("ignore_start_done_count", done_total - d0, 1);
    chk("ignore_start_result", int'(bcd_100) * 100 + int'(bcd_10) * 10 + int'(bcd_1), 37);

    // Reset at E4 aborts; then 200 converts normally.
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; bin_in = 8'd123; signed_mode = 1'b0;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b1;
    @(posedge clk); #1;                 // E4
    RESET = 1'b0;
    d0 = done_total;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_digits", int'({bcd_100, bcd_10, bcd_1}), 0);
    chk("abort_negative", int'(negative), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_total - d0, 0);
    run_conv("after_reset_200", 8'd200, 1'b0, 2, 0, 0, 0);

    // Start held high, operand stepping 0..255: one result every 10 cycles.
    wait_idle();
    @(posedge clk); #1;
    d0 = done_total;
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      bin_in = 8'(v);
      signed_mode = 1'($urandom);
      @(posedge clk); #1;               // accept edge
      bin_in = 8'(v + 1);
      repeat (9) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    d1 = done_total;
    chk("stream_done_count", d1 - d0, 256);

    // Random conversions with random interference, occasional reset.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      start = 1'b1; bin_in = 8'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
        start = 1'($urandom);
        bin_in = 8'($urandom);
        signed_mode = 1'($urandom);
        RESET = ($urandom_range(0, 29) == 0);
        @(posedge clk); #1;
      end
      RESET = 1'b0;
      start = 1'b0;
    end
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
